// File: rtl/gb_link_cable.sv
// Serial link cable between two Game Boy serial ports: 8-bit full-duplex
// MSB-first exchange, master-clocked, with a completion pulse per side.
module gb_link_side #(
    parameter int BIT_TICKS  = 512,
    parameter int FAST_TICKS = 16
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  logic       start,
    input  logic       int_clk,
    input  logic       fast,
    input  logic [7:0] tx,
    input  logic       peer_start_master,
    input  logic       peer_joinable,
    input  logic       peer_shift,
    input  logic       peer_wrap,
    input  logic       peer_msb,
    output logic [7:0] rx,
    output logic       done,
    output logic       busy,
    output logic       start_master,
    output logic       joinable,
    output logic       shift,
    output logic       wrap,
    output logic       msb
);
    localparam int TW = $clog2(BIT_TICKS);

    typedef enum logic [2:0] {IDLE, ARMED, SHIFT_MASTER, SHIFT_SLAVE, DONE} state_t;

    state_t        state;
    logic [7:0]    sr;
    logic [TW-1:0] tick;
    logic [2:0]    bitcnt;
    logic          fast_q;
    logic          linked;
    logic [TW-1:0] lim;

    assign lim          = fast_q ? TW'(FAST_TICKS - 1) : TW'(BIT_TICKS - 1);
    assign start_master = (state == IDLE) && start && int_clk;
    // A peer master may take this side along if it is armed or arming right now.
    assign joinable     = (state == ARMED) || ((state == IDLE) && start && !int_clk);
    assign shift        = (state == SHIFT_MASTER) && ce && (tick == lim);
    assign wrap         = shift && (bitcnt == 3'd7);
    assign msb          = sr[7];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sr     <= 8'hFF;
            rx     <= 8'hFF;
            tick   <= '0;
            bitcnt <= 3'd0;
            fast_q <= 1'b0;
            linked <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sr     <= tx;
                        fast_q <= fast;
                        tick   <= '0;
                        bitcnt <= 3'd0;
                        busy   <= 1'b1;
                        if (int_clk) begin
                            state  <= SHIFT_MASTER;
                            linked <= peer_joinable;
                        end else begin
                            state  <= peer_start_master ? SHIFT_SLAVE : ARMED;
                            linked <= 1'b0;
                        end
                    end
                end
                ARMED: begin
                    if (peer_start_master) state <= SHIFT_SLAVE;
                end
                SHIFT_MASTER: begin
                    if (ce) begin
                        if (tick == lim) begin
                            // An unlinked master sees an idle line, which reads as 1.
                            tick   <= '0;
                            sr     <= {sr[6:0], linked ? peer_msb : 1'b1};
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) state <= DONE;
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                end
                SHIFT_SLAVE: begin
                    if (peer_shift) sr <= {sr[6:0], peer_msb};
                    if (peer_wrap) state <= DONE;
                end
                DONE: begin
                    rx    <= sr;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module gb_link_cable #(
    parameter int BIT_TICKS  = 512,
    parameter int FAST_TICKS = 16
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  logic       a_start,
    input  logic       a_int_clk,
    input  logic       a_fast,
    input  logic [7:0] a_tx,
    output logic [7:0] a_rx,
    output logic       a_done,
    output logic       a_busy,
    input  logic       b_start,
    input  logic       b_int_clk,
    input  logic       b_fast,
    input  logic [7:0] b_tx,
    output logic [7:0] b_rx,
    output logic       b_done,
    output logic       b_busy
);
    logic a_sm, a_join, a_shift, a_wrap, a_msb;
    logic b_sm, b_join, b_shift, b_wrap, b_msb;

    gb_link_side #(.BIT_TICKS(BIT_TICKS), .FAST_TICKS(FAST_TICKS)) u_a (
        .clk_sys(clk_sys), .reset(reset), .ce(ce),
        .start(a_start), .int_clk(a_int_clk), .fast(a_fast), .tx(a_tx),
        .peer_start_master(b_sm), .peer_joinable(b_join), .peer_shift(b_shift),
        .peer_wrap(b_wrap), .peer_msb(b_msb),
        .rx(a_rx), .done(a_done), .busy(a_busy),
        .start_master(a_sm), .joinable(a_join), .shift(a_shift), .wrap(a_wrap), .msb(a_msb)
    );

    gb_link_side #(.BIT_TICKS(BIT_TICKS), .FAST_TICKS(FAST_TICKS)) u_b (
        .clk_sys(clk_sys), .reset(reset), .ce(ce),
        .start(b_start), .int_clk(b_int_clk), .fast(b_fast), .tx(b_tx),
        .peer_start_master(a_sm), .peer_joinable(a_join), .peer_shift(a_shift),
        .peer_wrap(a_wrap), .peer_msb(a_msb),
        .rx(b_rx), .done(b_done), .busy(b_busy),
        .start_master(b_sm), .joinable(b_join), .shift(b_shift), .wrap(b_wrap), .msb(b_msb)
    );
endmodule

// File: tb/tb_gb_link_cable.sv
// Scoreboard bench for gb_link_cable: stimulus pushes expected (rx, cycle)
// per side; a negedge monitor pops and compares on every done pulse.
module tb_gb_link_cable;
    logic       clk_sys = 0;
    logic       reset = 1;
    logic       ce = 1;
    logic       a_start = 0, a_int_clk = 0, a_fast = 0;
    logic [7:0] a_tx = 0;
    logic [7:0] a_rx;
    logic       a_done, a_busy;
    logic       b_start = 0, b_int_clk = 0, b_fast = 0;
    logic [7:0] b_tx = 0;
    logic [7:0] b_rx;
    logic       b_done, b_busy;

    gb_link_cable dut (
        .clk_sys(clk_sys), .reset(reset), .ce(ce),
        .a_start(a_start), .a_int_clk(a_int_clk), .a_fast(a_fast), .a_tx(a_tx),
        .a_rx(a_rx), .a_done(a_done), .a_busy(a_busy),
        .b_start(b_start), .b_int_clk(b_int_clk), .b_fast(b_fast), .b_tx(b_tx),
        .b_rx(b_rx), .b_done(b_done), .b_busy(b_busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0] rx;
        int         t;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    // Start sampled at edge N+1, 8 bits x 512 ticks, then one DONE cycle.
    localparam int SLOW = 4098;
    localparam int FASTC = 130;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (a_done) begin
                if (qa.size() == 0) check(0, "a_done_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = qa.pop_front();
                    check(a_rx == e.rx, "a_rx", int'(a_rx), int'(e.rx));
                    check(cyc == e.t, "a_done_time", cyc, e.t);
                end
            end
            if (b_done) begin
                if (qb.size() == 0) check(0, "b_done_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = qb.pop_front();
                    check(b_rx == e.rx, "b_rx", int'(b_rx), int'(e.rx));
                    check(cyc == e.t, "b_done_time", cyc, e.t);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic go(input bit sa, input bit ia, input bit fa, input logic [7:0] ta,
                      input bit sb, input bit ib, input bit fb, input logic [7:0] tbv);
        a_start = sa; a_int_clk = ia; a_fast = fa; a_tx = ta;
        b_start = sb; b_int_clk = ib; b_fast = fb; b_tx = tbv;
        @(negedge clk_sys);
        a_start = 0;
        b_start = 0;
    endtask

    task automatic push(input bit side_b, input logic [7:0] rx, input int t);
        exp_t e;
        e.rx = rx;
        e.t  = t;
        if (side_b) qb.push_back(e);
        else qa.push_back(e);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 20000) begin
            @(negedge clk_sys);
            n++;
        end
        check(qa.size() == 0 && qb.size() == 0, name, qa.size() + qb.size(), 0);
        tick(3);
    endtask

    initial begin
        int n;
        tick(3);
        check(a_rx == 8'hFF && b_rx == 8'hFF, "reset_rx", {a_rx, b_rx}, 16'hFFFF);
        check(!a_busy && !b_busy && !a_done && !b_done, "reset_flags",
              {a_busy, b_busy, a_done, b_done}, 0);
        reset = 0;
        tick(2);

        // Linked exchange, with a 50-cycle ce stall mid-transfer
        go(0, 0, 0, 8'h00, 1, 0, 0, 8'hC3);
        check(b_busy == 1'b1, "b_armed_busy", b_busy, 1);
        tick(4);
        n = cyc;
        push(0, 8'hC3, n + SLOW + 50);
        push(1, 8'h5A, n + SLOW + 50);
        go(1, 1, 0, 8'h5A, 0, 0, 0, 8'h00);
        tick(1000);
        ce = 0;
        tick(50);
        ce = 1;
        wait_empty("linked_timeout");
        check(!a_busy && !b_busy, "linked_idle", {a_busy, b_busy}, 0);

        // Solo master: B untouched
        n = cyc;
        push(0, 8'hFF, n + SLOW);
        go(1, 1, 0, 8'h12, 0, 0, 0, 8'h00);
        wait_empty("solo_timeout");
        check(b_rx == 8'h5A && !b_busy, "solo_b_untouched", {b_busy, b_rx}, 8'h5A);

        // Late arm in fast mode: A completes alone, B stays armed
        n = cyc;
        push(0, 8'hFF, n + FASTC);
        go(1, 1, 1, 8'h34, 0, 0, 0, 8'h00);
        tick(9);
        go(0, 0, 0, 8'h00, 1, 0, 0, 8'h96);
        wait_empty("late_arm_timeout");
        check(b_busy == 1'b1, "late_arm_b_busy", b_busy, 1);
        n = cyc;
        push(0, 8'h96, n + FASTC);
        push(1, 8'hAA, n + FASTC);
        go(1, 1, 1, 8'hAA, 0, 0, 0, 8'h00);
        wait_empty("restart_timeout");

        // Both internal on the same cycle: two solo transfers
        n = cyc;
        push(0, 8'hFF, n + SLOW);
        push(1, 8'hFF, n + SLOW);
        go(1, 1, 0, 8'h11, 1, 1, 0, 8'h22);
        wait_empty("dual_master_timeout");

        // Both external: armed forever, no done pulses
        go(1, 0, 0, 8'h11, 1, 0, 0, 8'h22);
        tick(600);
        check(a_busy && b_busy, "dual_armed_busy", {a_busy, b_busy}, 2'b11);
        reset = 1;
        #1;
        check(!a_busy && !b_busy, "dual_armed_reset", {a_busy, b_busy}, 0);
        tick(2);
        reset = 0;
        tick(2);

        // Mixed start on the same cycle links; mid-shift restart ignored
        n = cyc;
        push(0, 8'h0F, n + SLOW);
        push(1, 8'hF0, n + SLOW);
        go(1, 1, 0, 8'hF0, 1, 0, 0, 8'h0F);
        tick(2000);
        go(1, 1, 1, 8'h00, 1, 1, 1, 8'h00);
        wait_empty("busy_guard_timeout");

        // Reset after 3 shifts: immediate abort, no done
        go(0, 0, 0, 8'h00, 1, 0, 0, 8'h77);
        go(1, 1, 0, 8'h88, 0, 0, 0, 8'h00);
        tick(3 * 512 + 10);
        reset = 1;
        #1;
        check(!a_busy && !b_busy, "abort_busy", {a_busy, b_busy}, 0);
        check(a_rx == 8'hFF && b_rx == 8'hFF, "abort_rx", {a_rx, b_rx}, 16'hFFFF);
        tick(2);
        reset = 0;
        tick(20);
        n = cyc;
        push(0, 8'h3C, n + SLOW);
        push(1, 8'hC3, n + SLOW);
        go(1, 1, 0, 8'hC3, 1, 0, 0, 8'h3C);
        wait_empty("post_reset_timeout");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gb_link_cable.md
Name: gb_link_cable

Overview:
- Models the serial link cable between the two gb instances in the dual-Game-Boy top level.
- Sits between each instance's serial port (SB/SC register logic) and the other instance.
- Performs the 8-bit full-duplex MSB-first exchange at the Game Boy serial bit rate.
- Returns received bytes and a completion pulse to each side; each side uses the pulse to raise its serial IRQ and clear SC bit 7.

Parameters:
- BIT_TICKS, 512, ce ticks per serial bit (4.194304 MHz / 8192 Hz).
- FAST_TICKS, 16, ce ticks per bit when the master requests CGB fast clock.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous active-high reset
- ce  in  1  CPU clock enable; all tick counting is qualified by ce
- a_start  in  1  one-cycle pulse: side A wrote SC with bit 7 = 1
- a_int_clk  in  1  side A SC bit 0 (1 = internal clock / master), sampled with a_start
- a_fast  in  1  side A SC bit 1 (CGB fast), sampled with a_start
- a_tx  in  8  side A SB value, sampled with a_start
- a_rx  out  8  byte received by side A
- a_done  out  1  one-cycle pulse: side A transfer complete, a_rx valid
- a_busy  out  1  side A transfer armed or shifting
- b_start, b_int_clk, b_fast, b_tx, b_rx, b_done, b_busy: same as the A ports, for side B

Behaviour:
- Reset: a_rx = b_rx = 8'hFF; a_done = b_done = 0; a_busy = b_busy = 0; both sides IDLE; counters cleared.
- Reset mid-transfer aborts immediately. No done pulse is issued for the aborted transfer.
- Per-side states:
  - IDLE
  - ARMED (external clock, waiting for a peer clock)
  - SHIFT_MASTER (own clock)
  - SHIFT_SLAVE (clocked by peer)
  - DONE
- IDLE transitions:
  - start with int_clk = 1 -> SHIFT_MASTER.
  - start with int_clk = 0 -> ARMED.
  - In both cases, tx is loaded into the side's shift register and busy = 1 on the next cycle.
- A start pulse while busy = 1 is ignored. tx, int_clk and fast are not resampled.
- Peer joining:
  - A master entering SHIFT_MASTER takes its peer along only if the peer is ARMED in the same cycle. The peer moves to SHIFT_SLAVE.
  - A peer that arms after the master has started does not join; it stays ARMED.
- Simultaneous starts on the same cycle:
  - One side internal, one external: the pair is linked as master + slave.
  - Both internal: two independent solo transfers.
  - Both external: both stay ARMED indefinitely.
- Solo master (no linked peer): the incoming bit is 1 every shift, so rx = 8'hFF.
- Bit timing:
  - Master tick counter counts ce pulses up to BIT_TICKS (or FAST_TICKS if fast was sampled with start).
  - Reaching terminal count generates one shift event and reloads the counter.
  - The first shift occurs BIT_TICKS ce ticks after the start cycle.
- Shift event for a linked pair, in the same cycle:
  - a_sr <= {a_sr[6:0], b_sr[7]}
  - b_sr <= {b_sr[6:0], a_sr[7]}
  - A 3-bit counter increments per shift.
- After the 8th shift (counter wraps 7 -> 0), each participating side goes to DONE.
- DONE (one clk_sys cycle):
  - rx <= sr, done = 1, then -> IDLE with busy = 0.
  - A linked pair pulses a_done and b_done in the same cycle.
- rx holds its value until the next completion. rx is never updated on abort.
- A start pulse in the DONE cycle is ignored. A start in the first IDLE cycle after DONE is accepted.
- An ARMED side stays ARMED with no timeout. busy remains 1 throughout.
- ce low holds all counters. Handshake outputs (done) are pulses in clk_sys, independent of ce.

Test Plan:
- Linked exchange: A start internal, tx 8'h5A; B armed external earlier, tx 8'hC3 -> after 8×512 ce ticks, a_rx = 8'hC3 and b_rx = 8'h5A, with a_done and b_done pulsing together for exactly one cycle.
- Solo master: B idle; A start internal, tx 8'h12 -> a_rx = 8'hFF after 4096 ce ticks; b_done never asserts; b_rx unchanged.
- Late arm and fast mode: A master starts with a_fast = 1; B arms 10 ce ticks later -> A completes alone at 8×16 ticks with a_rx = 8'hFF; B stays busy. A restarts, tx 8'hAA -> b_rx = 8'hAA, a_rx = B's tx.
- Arbitration: both sides start internal in the same cycle -> two independent completions, both rx = 8'hFF. Both start external -> both busy indefinitely, no done pulses.
- Busy guard: a second a_start with tx 8'h00 issued mid-shift -> ignored; the original byte is transferred.
- Reset: assert reset after 3 shifts -> busy = 0, rx = 8'hFF immediately, no done pulse. A fresh transfer after reset completes normally.
